// File: rtl/regf_pkg.sv
// Shared definitions for the register-file write-back arbiter: default widths,
// requester index constants and a one-hot to index helper.
package regf_pkg;

  localparam int unsigned DEF_AWIDTH = 5;
  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned MAX_REQ    = 4;
  localparam int unsigned IDX_W      = 2;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_EXT  = 2;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regf_rr_pick.sv
// Combinational rotate-priority picker: the first set bit of valid, searching
// upward from ptr and wrapping, becomes the single set bit of grant.
module regf_rr_pick
  import regf_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic found;

  // Two passes: indices at or above ptr first, then the wrapped lower part.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && valid[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && valid[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regf_wb_arbiter.sv
// Write-back port C arbiter: one-hot grant among NREQ requesters, registered port C outputs.
// Define REGF_WB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module regf_wb_arbiter
  import regf_pkg::*;
#(
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   flush_pipeline,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wec,
  output logic [AWIDTH-1:0]      addrc,
  output logic [DWIDTH-1:0]      datac,
  output logic                   wb_busy
);

  logic              eligible;
  logic              any_grant;
  logic [NREQ-1:0]   grant;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;

  // Reset is included so no grant is advertised while the arbiter is held in reset.
  assign eligible = !reset && !halt && !flush_pipeline;

`ifdef REGF_WB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gidx;
  logic [MAX_REQ-1:0] ready_ext;

  regf_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant)
  );

  always_comb begin
    ready_ext             = '0;
    ready_ext[NREQ-1:0]   = req_ready;
    gidx                  = onehot_to_idx(ready_ext);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
`endif

  assign req_ready = eligible ? grant : '0;
  assign any_grant = |req_ready;
  assign wb_busy   = |(req_valid & ~req_ready);

  // req_ready is one-hot, so OR-ing the masked slices selects the winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_ready[i]) begin
        sel_addr = sel_addr | req_addr[i*AWIDTH +: AWIDTH];
        sel_data = sel_data | req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wec   <= 1'b0;
      addrc <= '0;
      datac <= '0;
    end else begin
      wec <= any_grant;
      if (any_grant) begin
        addrc <= sel_addr;
        datac <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed self-checking bench for regf_wb_arbiter (NREQ=3, AWIDTH=5, DWIDTH=32).
module tb_regf_wb_arbiter;
  import regf_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            halt;
  logic            flush_pipeline;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            wec;
  logic [AW-1:0]   addrc;
  logic [DW-1:0]   datac;
  logic            wb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  regf_wb_arbiter #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .NREQ  (NR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .halt          (halt),
    .flush_pipeline(flush_pipeline),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .wec           (wec),
    .addrc         (addrc),
    .datac         (datac),
    .wb_busy       (wb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] t3_ready [6];
  logic [DW-1:0] t3_data  [6];

  initial begin
    reset          = 1'b1;
    halt           = 1'b0;
    flush_pipeline = 1'b0;
    req_valid      = 3'b111;
    req_addr       = '0;
    req_data       = '0;
    set_req(REQ_ALU, 5'd1, 32'h100);
    set_req(REQ_LOAD, 5'd2, 32'h200);
    set_req(REQ_EXT, 5'd3, 32'h300);

    // T1 reset with all requesters valid
    #1;
    chk("t1_ready", 64'(req_ready), 64'(3'b000));
    chk("t1_busy", 64'(wb_busy), 64'(1'b1));
    tick();
    tick();
    chk("t1_wec", 64'(wec), 64'(1'b0));
    chk("t1_addrc", 64'(addrc), 64'(5'd0));
    chk("t1_datac", 64'(datac), 64'(32'd0));
    chk("t1_ready_held", 64'(req_ready), 64'(3'b000));
    reset     = 1'b0;
    req_valid = 3'b000;
    #1;
    chk("t1_idle_ready", 64'(req_ready), 64'(3'b000));
    chk("t1_idle_busy", 64'(wb_busy), 64'(1'b0));

    // T2 single requester
    set_req(REQ_LOAD, 5'd7, 32'hA5A5_0001);
    req_valid = 3'b010;
    #1;
    chk("t2_ready", 64'(req_ready), 64'(3'b010));
    chk("t2_busy", 64'(wb_busy), 64'(1'b0));
    tick();
    chk("t2_wec", 64'(wec), 64'(1'b1));
    chk("t2_addrc", 64'(addrc), 64'(5'd7));
    chk("t2_datac", 64'(datac), 64'(32'hA5A5_0001));
    req_valid = 3'b000;
    tick();
    chk("t2_wec_off", 64'(wec), 64'(1'b0));
    chk("t2_addrc_hold", 64'(addrc), 64'(5'd7));
    chk("t2_datac_hold", 64'(datac), 64'(32'hA5A5_0001));

    // Grant requester 2 so the round-robin pointer wraps back to 0
    set_req(REQ_LOAD, 5'd2, 32'h200);
    req_valid = 3'b100;
    #1;
    chk("pre3_ready", 64'(req_ready), 64'(3'b100));
    tick();
    chk("pre3_datac", 64'(datac), 64'(32'h300));
    req_valid = 3'b000;
    tick();

    // T3 all three valid for six cycles
`ifdef REGF_WB_FIXED_PRIO_EN
    for (int k = 0; k < 6; k++) begin
      t3_ready[k] = 3'b001;
      t3_data[k]  = 32'h100;
    end
`else
    t3_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    t3_data  = '{32'h100, 32'h200, 32'h300, 32'h100, 32'h200, 32'h300};
`endif
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'(t3_ready[k]));
      chk($sformatf("t3_busy_%0d", k), 64'(wb_busy), 64'(1'b1));
      @(posedge clk);
      #1;
      chk($sformatf("t3_wec_%0d", k), 64'(wec), 64'(1'b1));
      chk($sformatf("t3_datac_%0d", k), 64'(datac), 64'(t3_data[k]));
    end
    req_valid = 3'b000;
    tick();
    chk("t3_wec_off", 64'(wec), 64'(1'b0));

    // T4 halt for three cycles
    req_valid = 3'b001;
    halt      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_ready_%0d", k), 64'(req_ready), 64'(3'b000));
      chk($sformatf("t4_busy_%0d", k), 64'(wb_busy), 64'(1'b1));
      @(posedge clk);
      #1;
      chk($sformatf("t4_wec_%0d", k), 64'(wec), 64'(1'b0));
    end
    halt = 1'b0;
    #1;
    chk("t4_ready_after", 64'(req_ready), 64'(3'b001));
    tick();
    chk("t4_wec_after", 64'(wec), 64'(1'b1));
    chk("t4_datac_after", 64'(datac), 64'(32'h100));

    // T5 grant in N, flush in N+1
    req_valid = 3'b010;
    #1;
    chk("t5_ready_n", 64'(req_ready), 64'(3'b010));
    tick();
    flush_pipeline = 1'b1;
    req_valid      = 3'b110;
    #1;
    chk("t5_wec_n1", 64'(wec), 64'(1'b1));
    chk("t5_datac_n1", 64'(datac), 64'(32'h200));
    chk("t5_ready_n1", 64'(req_ready), 64'(3'b000));
    chk("t5_busy_n1", 64'(wb_busy), 64'(1'b1));
    tick();
    chk("t5_wec_n2", 64'(wec), 64'(1'b0));
    flush_pipeline = 1'b0;
    req_valid      = 3'b000;

    // Grant requester 0 so the pointer sits at 1 for T6
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    tick();

    // T6 same address from requesters 0 and 1
    set_req(REQ_ALU, 5'd5, 32'd11);
    set_req(REQ_LOAD, 5'd5, 32'd22);
    req_valid = 3'b011;
    #1;
`ifdef REGF_WB_FIXED_PRIO_EN
    chk("t6_ready_first", 64'(req_ready), 64'(3'b001));
    tick();
    chk("t6_addrc_first", 64'(addrc), 64'(5'd5));
    chk("t6_datac_first", 64'(datac), 64'(32'd11));
    req_valid = 3'b010;
    #1;
    chk("t6_ready_second", 64'(req_ready), 64'(3'b010));
    tick();
    chk("t6_addrc_final", 64'(addrc), 64'(5'd5));
    chk("t6_datac_final", 64'(datac), 64'(32'd22));
`else
    chk("t6_ready_first", 64'(req_ready), 64'(3'b010));
    tick();
    chk("t6_addrc_first", 64'(addrc), 64'(5'd5));
    chk("t6_datac_first", 64'(datac), 64'(32'd22));
    req_valid = 3'b001;
    #1;
    chk("t6_ready_second", 64'(req_ready), 64'(3'b001));
    tick();
    chk("t6_addrc_final", 64'(addrc), 64'(5'd5));
    chk("t6_datac_final", 64'(datac), 64'(32'd11));
`endif
    chk("t6_wec_final", 64'(wec), 64'(1'b1));
    req_valid = 3'b000;
    tick();
    chk("t6_wec_off", 64'(wec), 64'(1'b0));
    chk("t6_addrc_hold", 64'(addrc), 64'(5'd5));

    // Asynchronous reset mid-operation
    req_valid = 3'b100;
    tick();
    chk("ar_wec_before", 64'(wec), 64'(1'b1));
    chk("ar_datac_before", 64'(datac), 64'(32'h300));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_wec", 64'(wec), 64'(1'b0));
    chk("ar_addrc", 64'(addrc), 64'(5'd0));
    chk("ar_datac", 64'(datac), 64'(32'd0));
    chk("ar_ready", 64'(req_ready), 64'(3'b000));
    tick();
    reset     = 1'b0;
    req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
